bru_bp: RTL and testbench

BRU_BP -- requirements
Module: bru_bp

---
 rtl/bru_bp.sv | 175 +++++++++++++++++
 tb/tb_bru_bp.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bru_bp.sv
// Branch resolution unit and direct-mapped branch predictor with fetch PC.
// Ports: i_clk/i_rst; fetch (i_pcwen, o_pc, o_pred_*); execute (i_ex_*, operands); o_flush, counters.
module bru_bp #(
  parameter int              XLEN      = 64,
  parameter int              BTB_DEPTH = 64,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(64'h80000000),
  parameter bit              PRED_EN   = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_pcwen,
  input  logic            i_ex_valid,
  input  logic            i_jal,
  input  logic            i_jalr,
  input  logic            i_brch,
  input  logic [2:0]      i_bfun3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic            i_ex_pred_taken,
  input  logic [XLEN-1:0] i_ex_pred_tgt,
  output logic [XLEN-1:0] o_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_tgt,
  output logic            o_flush,
  output logic [31:0]     o_br_cnt,
  output logic [31:0]     o_mis_cnt
);

  localparam int IDX  = $clog2(BTB_DEPTH);
  localparam int TAGW = XLEN - IDX - 2;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [BTB_DEPTH-1:0] vld_q;
  logic [31:0] br_cnt_q, mis_cnt_q;

  logic [TAGW-1:0] tag_mem [BTB_DEPTH];
  logic [XLEN-1:0] tgt_mem [BTB_DEPTH];
  logic [1:0]      ctr_mem [BTB_DEPTH];

  // fetch-side lookup
  logic [IDX-1:0]  lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;
  logic [XLEN-1:0] pc_plus4;

  assign lk_idx   = pc_q[IDX+1:2];
  assign lk_tag   = pc_q[XLEN-1:IDX+2];
  assign lk_hit   = vld_q[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign pc_plus4 = pc_q + XLEN'(4);

  assign o_pc         = pc_q;
  assign o_pred_taken = PRED_EN && lk_hit && ctr_mem[lk_idx][1];
  assign o_pred_tgt   = o_pred_taken ? tgt_mem[lk_idx] : pc_plus4;

  // branch condition
  logic          eq, lt;
  logic [XLEN:0] sub;
  logic          ltu;
  logic          cond;

  assign eq  = (i_rs1 == i_rs2);
  assign lt  = ($signed(i_rs1) < $signed(i_rs2));
  // borrow out of an XLEN+1-bit subtract gives unsigned less-than
  assign sub = {1'b0, i_rs1} - {1'b0, i_rs2};
  assign ltu = sub[XLEN];

  always_comb begin
    cond = 1'b0;
    case (i_bfun3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt;
      3'b101:  cond = !lt;
      3'b110:  cond = ltu;
      3'b111:  cond = !ltu;
      default: cond = 1'b0;
    endcase
  end

  // resolution
  logic            act_taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] act_tgt;
  logic [XLEN-1:0] ex_plus4;
  logic            mispredict;
  logic            is_ctl;
  logic            upd;

  assign is_ctl    = i_jal | i_jalr | i_brch;
  assign act_taken = i_jal | i_jalr | (i_brch & cond);
  assign jalr_sum  = i_rs1 + i_imm;
  assign act_tgt   = i_jalr ? {jalr_sum[XLEN-1:1], 1'b0}
                            : i_ex_pc + i_imm;
  assign ex_plus4  = i_ex_pc + XLEN'(4);

  always_comb begin
    mispredict = 1'b0;
    if (i_ex_valid) begin
      if (act_taken != i_ex_pred_taken)
        mispredict = 1'b1;
      else if (act_taken && (act_tgt != i_ex_pred_tgt))
        mispredict = 1'b1;
    end
  end

  assign o_flush = mispredict;
  assign upd     = i_ex_valid & is_ctl;

  // next PC
  always_comb begin
    pc_d = pc_q;
    if (mispredict)
      pc_d = act_taken ? act_tgt : ex_plus4;
    else if (i_pcwen)
      pc_d = o_pred_tgt;
  end

  // execute-side predictor update
  logic [IDX-1:0]  ex_idx;
  logic [TAGW-1:0] ex_tag;
  logic            ex_hit;
  logic [1:0]      ex_ctr;
  logic [1:0]      ctr_d;
  logic            wr_en;

  assign ex_idx = i_ex_pc[IDX+1:2];
  assign ex_tag = i_ex_pc[XLEN-1:IDX+2];
  assign ex_hit = vld_q[ex_idx] && (tag_mem[ex_idx] == ex_tag);
  assign ex_ctr = ctr_mem[ex_idx];

  always_comb begin
    ctr_d = 2'b10;
    if (ex_hit) begin
      if (act_taken)
        ctr_d = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'b01;
      else
        ctr_d = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'b01;
    end
  end

  // a miss that resolves not-taken leaves the entry alone
  assign wr_en = upd && !i_rst && (ex_hit || act_taken);

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      tag_mem[ex_idx] <= ex_tag;
      ctr_mem[ex_idx] <= ctr_d;
      if (act_taken)
        tgt_mem[ex_idx] <= act_tgt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q      <= RESET_PC;
      vld_q     <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (wr_en)
        vld_q[ex_idx] <= 1'b1;
      if (upd)
        br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict)
        mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign o_br_cnt  = br_cnt_q;
  assign o_mis_cnt = mis_cnt_q;

endmodule

// File: tb/tb_bru_bp.sv
// Self-checking bench for bru_bp: directed scenarios then random traffic.
// Expected values come from a table-based predictor model kept here.
module tb_bru_bp;

  localparam int          DEPTH = 64;
  localparam logic [63:0] RPC   = 64'h80000000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pcwen, ex_valid, jal, jalr, brch, pt;
  logic [2:0]  f3;
  logic [63:0] rs1, rs2, imm, ex_pc, ptgt;
  logic [63:0] pc;
  logic        pred;
  logic [63:0] pred_tgt;
  logic        flush;
  logic [31:0] br_cnt, mis_cnt;

  bru_bp #(
    .XLEN(64), .BTB_DEPTH(DEPTH), .RESET_PC(RPC), .PRED_EN(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pcwen(pcwen),
    .i_ex_valid(ex_valid), .i_jal(jal), .i_jalr(jalr),
    .i_brch(brch), .i_bfun3(f3), .i_rs1(rs1), .i_rs2(rs2),
    .i_imm(imm), .i_ex_pc(ex_pc), .i_ex_pred_taken(pt),
    .i_ex_pred_tgt(ptgt), .o_pc(pc), .o_pred_taken(pred),
    .o_pred_tgt(pred_tgt), .o_flush(flush),
    .o_br_cnt(br_cnt), .o_mis_cnt(mis_cnt)
  );

  int errs = 0;
  int checks = 0;

  // model: table of entries keyed by (pc/4) mod DEPTH, tag = pc/(4*DEPTH)
  logic [63:0] m_pc;
  logic [31:0] m_br, m_mis;
  bit          mv   [DEPTH];
  logic [63:0] mtag [DEPTH];
  logic [63:0] mtgt [DEPTH];
  int          mctr [DEPTH];

  function automatic int ix(logic [63:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [63:0] tg(logic [63:0] a);
    return a / (4 * DEPTH);
  endfunction

  task automatic mpred(input logic [63:0] a, output bit t,
                       output logic [63:0] tt);
    int i;
    i = ix(a);
    t = mv[i] && (mtag[i] == tg(a)) && (mctr[i] >= 2);
    tt = t ? mtgt[i] : a + 64'd4;
  endtask

  function automatic bit cond_of(logic [2:0] f, logic [63:0] a,
                                 logic [63:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC;
    m_br = 0;
    m_mis = 0;
    for (int i = 0; i < DEPTH; i++) mv[i] = 0;
  endtask

  task automatic idle();
    ex_valid = 0; jal = 0; jalr = 0; brch = 0; f3 = 0;
    rs1 = 0; rs2 = 0; imm = 0; ex_pc = 0; pt = 0; ptgt = 0;
  endtask

  // kind: 0 none, 1 jal, 2 jalr, 3 branch
  task automatic set_ex(input int kind, input logic [2:0] f,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] im, input logic [63:0] epc,
                        input logic p, input logic [63:0] pg);
    ex_valid = 1;
    jal = (kind == 1); jalr = (kind == 2); brch = (kind == 3);
    f3 = f; rs1 = a; rs2 = b; imm = im; ex_pc = epc;
    pt = p; ptgt = pg;
  endtask

  // one clock: check combinational outputs, clock, check state
  task automatic step(input string tag);
    bit          ep, tk, mis, upd, hit;
    logic [63:0] et, at, npc;
    int          i;
    mpred(m_pc, ep, et);
    tk  = jal | jalr | (brch & cond_of(f3, rs1, rs2));
    at  = jalr ? ((rs1 + imm) & ~64'd1) : ex_pc + imm;
    mis = ex_valid && ((tk != pt) || (tk && pt && at != ptgt));
    upd = ex_valid && (jal | jalr | brch);
    #3;
    chk({tag, ":pc"}, pc, m_pc);
    chk({tag, ":pred"}, 64'(pred), 64'(ep));
    chk({tag, ":ptgt"}, pred_tgt, et);
    chk({tag, ":flush"}, 64'(flush), 64'(mis));
    if (rst) npc = RPC;
    else if (mis) npc = tk ? at : ex_pc + 64'd4;
    else if (pcwen) npc = et;
    else npc = m_pc;
    if (rst) begin
      model_reset();
    end else begin
      if (upd) begin
        i = ix(ex_pc);
        hit = mv[i] && (mtag[i] == tg(ex_pc));
        if (hit) begin
          mctr[i] = tk ? ((mctr[i] < 3) ? mctr[i] + 1 : 3)
                       : ((mctr[i] > 0) ? mctr[i] - 1 : 0);
          if (tk) mtgt[i] = at;
        end else if (tk) begin
          mv[i] = 1; mtag[i] = tg(ex_pc); mtgt[i] = at; mctr[i] = 2;
        end
        m_br = m_br + 1;
      end
      if (mis) m_mis = m_mis + 1;
    end
    m_pc = npc;
    @(posedge clk);
    #1;
    chk({tag, ":npc"}, pc, m_pc);
    chk({tag, ":brc"}, 64'(br_cnt), 64'(m_br));
    chk({tag, ":misc"}, 64'(mis_cnt), 64'(m_mis));
  endtask

  // steer fetch to a PC with a mispredicted JAL
  task automatic redirect(input logic [63:0] to);
    set_ex(1, 0, 0, 0, to - 64'h80000800, 64'h80000800, 0, 0);
    pcwen = 0;
    step("redir");
    idle();
  endtask

  function automatic logic [63:0] rval();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  bit          rp;
  logic [63:0] rt;
  logic [11:0] r12;

  initial begin
    idle();
    rst = 1; pcwen = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst:pc", pc, RPC);
    chk("rst:pred", 64'(pred), 64'd0);
    chk("rst:ptgt", pred_tgt, RPC + 64'd4);
    chk("rst:brc", 64'(br_cnt), 64'd0);
    chk("rst:misc", 64'(mis_cnt), 64'd0);
    rst = 0;

    // sequential fetch
    pcwen = 1;
    repeat (3) step("seq");
    chk("seq:pc", pc, 64'h8000000C);
    pcwen = 0;

    // BNE taken, predicted not-taken: allocate
    set_ex(3, 3'd1, 1, 2, -64'd16, 64'h80000010, 0, 0);
    step("bne1");
    chk("bne1:pc", pc, 64'h80000000);
    idle();
    pcwen = 1;
    repeat (4) step("walk");
    pcwen = 0;
    chk("alloc:pred", 64'(pred), 64'd1);
    chk("alloc:ptgt", pred_tgt, 64'h80000000);

    // three more taken, then one not-taken
    repeat (3) begin
      set_ex(3, 3'd1, 1, 2, -64'd16, 64'h80000010, 1, 64'h80000000);
      step("bne_t");
    end
    set_ex(3, 3'd1, 5, 5, -64'd16, 64'h80000010, 1, 64'h80000000);
    step("bne_nt");
    chk("bne_nt:misc", 64'(mis_cnt), 64'd2);
    redirect(64'h80000010);
    step("sat:look");
    chk("sat:pred", 64'(pred), 64'd1);

    // JALR bit-0 clear
    set_ex(2, 0, 64'h80001001, 0, 0, 64'h80000200, 1, 64'h80001000);
    step("jalr_ok");
    set_ex(2, 0, 64'h80001001, 0, 0, 64'h80000200, 1, 64'h80002000);
    step("jalr_bad");
    chk("jalr:pc", pc, 64'h80001000);
    idle();

    // aliasing overwrite
    set_ex(3, 3'd0, 7, 7, -64'h110, 64'h80000110, 0, 0);
    step("alias");
    redirect(64'h80000010);
    step("alias:look");
    chk("alias:pred", 64'(pred), 64'd0);

    // mispredict while fetch stalled
    set_ex(1, 0, 0, 0, 64'h100, 64'h80000300, 0, 0);
    pcwen = 0;
    step("stall_mis");
    chk("stall:pc", pc, 64'h80000400);
    // reset together with a mispredict
    set_ex(1, 0, 0, 0, 64'h100, 64'h80000300, 0, 0);
    rst = 1;
    step("rst_mis");
    rst = 0;
    idle();
    chk("rst_mis:pc", pc, 64'h80000000);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int kind;
      logic [63:0] epc, a, b, im, gt;
      bit tk;
      kind = $urandom_range(0, 5);
      kind = (kind >= 3) ? ((kind == 5) ? 0 : 3) : kind;
      epc = 64'h80000000 + 64'($urandom_range(0, 15)) * 4
            + 64'($urandom_range(0, 1)) * 256;
      a = rval();
      b = ($urandom_range(0, 3) == 0) ? a : rval();
      r12 = 12'($urandom);
      im = {{52{r12[11]}}, r12[11:1], 1'b0};
      set_ex(kind, 3'($urandom_range(0, 7)), a, b, im, epc, 0, 0);
      ex_valid = ($urandom_range(0, 3) != 0);
      tk = jal | jalr | (brch & cond_of(f3, a, b));
      gt = jalr ? ((a + im) & ~64'd1) : epc + im;
      case ($urandom_range(0, 2))
        0: begin mpred(epc, rp, rt); pt = rp; ptgt = rt; end
        1: begin pt = tk; ptgt = gt; end
        default: begin
          pt = 1'($urandom);
          ptgt = $urandom_range(0, 1) ? gt : gt + 64'd8;
        end
      endcase
      pcwen = 1'($urandom);
      step("rnd");
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
